// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches words over an I_RD/I_RDY handshake.
// Optional macro FETCH_BYPASS_EN forwards I_DATA straight into IR when IR_LD meets I_RDY.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PC_CLR,
    input  logic              PC_IC,
    input  logic              IR_LD,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] PC,
    output logic              FETCH_RDY,
    output logic              LD_MISS,
    output logic [ADDR_W-1:0] I_ADDR,
    output logic              I_RD,
    input  logic [DATA_W-1:0] I_DATA,
    input  logic              I_RDY
);

    typedef enum logic [1:0] {
        ST_LAUNCH,
        ST_FETCH,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   fb_q, fb_d;
    logic [ADDR_W-1:0]   i_addr_q, i_addr_d;
    logic                stale_q, stale_d;
    logic                ld_miss_q, ld_miss_d;
    logic                pc_change;
    logic                word_accept;

    assign pc_change   = PC_CLR | PC_IC;
    assign word_accept = (state_q == ST_FETCH) && I_RDY && !stale_q && !pc_change;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        fb_d      = fb_q;
        i_addr_d  = i_addr_q;
        stale_d   = stale_q;
        ld_miss_d = 1'b0;

        if (PC_CLR) begin
            pc_d = RESET_PC;
        end else if (PC_IC) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end

        if (IR_LD) begin
            if (state_q == ST_READY) begin
                ir_d = fb_q;
            end else begin
`ifdef FETCH_BYPASS_EN
                if (word_accept) begin
                    ir_d = I_DATA;
                end else begin
                    ld_miss_d = 1'b1;
                end
`else
                ld_miss_d = 1'b1;
`endif
            end
        end

        // A PC command landing in LAUNCH is folded into the address being issued.
        case (state_q)
            ST_LAUNCH: begin
                i_addr_d = pc_d;
                stale_d  = 1'b0;
                state_d  = ST_FETCH;
            end
            ST_FETCH: begin
                if (I_RDY) begin
                    if (word_accept) begin
                        fb_d    = I_DATA;
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end else if (pc_change) begin
                    stale_d = 1'b1;
                end
            end
            ST_READY: begin
                if (pc_change) begin
                    state_d = ST_LAUNCH;
                end
            end
            default: begin
                state_d = ST_LAUNCH;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_LAUNCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            fb_q      <= '0;
            i_addr_q  <= '0;
            stale_q   <= 1'b0;
            ld_miss_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            fb_q      <= fb_d;
            i_addr_q  <= i_addr_d;
            stale_q   <= stale_d;
            ld_miss_q <= ld_miss_d;
        end
    end

    assign IR        = ir_q;
    assign PC        = pc_q;
    assign FETCH_RDY = (state_q == ST_READY);
    assign I_RD      = (state_q == ST_FETCH);
    assign LD_MISS   = ld_miss_q;
    assign I_ADDR    = i_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: command vector table, hand-written corner sequences,
// a behavioural instruction ROM with programmable latency, and an IR scoreboard.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pc_clr = 1'b0;
    logic        pc_ic = 1'b0;
    logic        ir_ld = 1'b0;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        fetch_rdy;
    logic        ld_miss;
    logic [7:0]  i_addr;
    logic        i_rd;
    logic [15:0] i_data;
    logic        i_rdy;

    int          checks = 0;
    int          errors = 0;
    int          latency = 1;
    int          mem_cnt;
    logic [15:0] mem [256];
    logic [7:0]  exp_pc = 8'h00;
    logic [15:0] sbq [$];

    typedef struct {
        logic        clr;
        logic        ic;
        logic        ld;
        int          lat;
        logic [7:0]  exp_pc;
        logic [15:0] exp_ir;
    } vec_t;

    vec_t vecs [8];

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00)) dut (
        .Clock(clock),
        .Reset(reset),
        .PC_CLR(pc_clr),
        .PC_IC(pc_ic),
        .IR_LD(ir_ld),
        .IR(ir),
        .PC(pc),
        .FETCH_RDY(fetch_rdy),
        .LD_MISS(ld_miss),
        .I_ADDR(i_addr),
        .I_RD(i_rd),
        .I_DATA(i_data),
        .I_RDY(i_rdy)
    );

    always #5 clock = ~clock;

    // ROM: I_RDY pulses once I_RD has been held for more than `latency` cycles.
    initial begin
        i_rdy   = 1'b0;
        i_data  = 16'h0000;
        mem_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset || !i_rd || i_rdy) begin
                i_rdy   = 1'b0;
                mem_cnt = 0;
            end else begin
                mem_cnt++;
                if (mem_cnt > latency) begin
                    i_rdy  = 1'b1;
                    i_data = mem[i_addr];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!fetch_rdy && n < 60) begin
            tick();
            n++;
        end
        if (!fetch_rdy) checkOutput("ready_timeout", {31'd0, fetch_rdy}, 32'd1);
    endtask

    task automatic waitRd();
        int n = 0;
        while (!i_rd && n < 60) begin
            tick();
            n++;
        end
        if (!i_rd) checkOutput("rd_timeout", {31'd0, i_rd}, 32'd1);
    endtask

    task automatic applyStimulus(input logic clr, input logic ic, input logic ld);
        logic rdy_before;
        logic irdy_snap;
        pc_clr     = clr;
        pc_ic      = ic;
        ir_ld      = ld;
        rdy_before = fetch_rdy;
        if (ld && rdy_before) sbq.push_back(mem[exp_pc]);
        @(negedge clock);
        #1;
        irdy_snap = i_rdy;
        tick();
        pc_clr = 1'b0;
        pc_ic  = 1'b0;
        ir_ld  = 1'b0;
        if (clr) exp_pc = 8'h00;
        else if (ic) exp_pc = exp_pc + 8'h01;
        checkOutput("pc", {24'd0, pc}, {24'd0, exp_pc});
        if (sbq.size() > 0) checkOutput("ir_sb", {16'd0, ir}, {16'd0, sbq.pop_front()});
        if (ld && !irdy_snap) checkOutput("ld_miss", {31'd0, ld_miss}, {31'd0, !rdy_before});
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'h5000 | 16'(i);
        mem[0] = 16'h1A95;
        mem[1] = 16'h2A95;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1, 8'h00, 16'h1A95};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 3, 8'h01, 16'h1A95};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1, 8'h01, 16'h2A95};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 2, 8'h02, 16'h2A95};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1, 8'h02, 16'h5002};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1, 8'h02, 16'h5002};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 2, 8'h00, 16'h5002};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1, 8'h00, 16'h1A95};

        tick();
        tick();
        checkOutput("rst_i_rd", {31'd0, i_rd}, 32'd0);
        checkOutput("rst_pc", {24'd0, pc}, 32'd0);
        checkOutput("rst_ir", {16'd0, ir}, 32'd0);
        checkOutput("rst_rdy", {31'd0, fetch_rdy}, 32'd0);
        checkOutput("rst_miss", {31'd0, ld_miss}, 32'd0);
        checkOutput("rst_addr", {24'd0, i_addr}, 32'd0);

        latency = 1;
        reset   = 1'b0;
        tick();
        checkOutput("first_rd", {31'd0, i_rd}, 32'd1);
        checkOutput("first_addr", {24'd0, i_addr}, 32'd0);
        tick();
        checkOutput("first_rdy_early", {31'd0, fetch_rdy}, 32'd0);
        tick();
        checkOutput("first_rdy", {31'd0, fetch_rdy}, 32'd1);

        for (int k = 0; k < 8; k++) begin
            waitReady();
            latency = vecs[k].lat;
            applyStimulus(vecs[k].clr, vecs[k].ic, vecs[k].ld);
            checkOutput($sformatf("vec%0d_pc", k), {24'd0, pc}, {24'd0, vecs[k].exp_pc});
            checkOutput($sformatf("vec%0d_ir", k), {16'd0, ir}, {16'd0, vecs[k].exp_ir});
            checkOutput($sformatf("vec%0d_rdy", k), {31'd0, fetch_rdy}, {31'd0, !(vecs[k].clr | vecs[k].ic)});
            if (vecs[k].clr | vecs[k].ic) begin
                waitRd();
                checkOutput($sformatf("vec%0d_addr", k), {24'd0, i_addr}, {24'd0, vecs[k].exp_pc});
            end
        end

        // PC_CLR while a request is in flight: request held, word dropped, refetch from 0.
        latency = 4;
        for (int k = 0; k < 5; k++) begin
            waitReady();
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        waitRd();
        checkOutput("stale_addr5", {24'd0, i_addr}, 32'h05);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("stale_rd_held", {31'd0, i_rd}, 32'd1);
        checkOutput("stale_addr_held", {24'd0, i_addr}, 32'h05);
        n = 0;
        while (i_rd && n < 20) begin
            tick();
            n++;
        end
        checkOutput("stale_rd_drop", {31'd0, i_rd}, 32'd0);
        checkOutput("stale_no_rdy", {31'd0, fetch_rdy}, 32'd0);
        tick();
        checkOutput("stale_refetch_rd", {31'd0, i_rd}, 32'd1);
        checkOutput("stale_refetch_addr", {24'd0, i_addr}, 32'h00);
        waitReady();
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Walk PC to 8'hFF, then wrap and check PC_CLR priority.
        latency = 1;
        for (int k = 0; k < 255; k++) begin
            waitReady();
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        waitReady();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("wrap_pc", {24'd0, pc}, 32'h00);
        checkOutput("wrap_rdy", {31'd0, fetch_rdy}, 32'd0);
        waitRd();
        checkOutput("wrap_addr", {24'd0, i_addr}, 32'h00);
        waitReady();
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitReady();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("clr_prio", {24'd0, pc}, 32'h00);
        waitReady();

        // IR_LD during FETCH: miss pulse, then IR_LD coinciding with I_RDY.
        latency = 3;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitRd();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("miss_ir_kept", {16'd0, ir}, 32'h50FF);
        tick();
        checkOutput("miss_pulse_end", {31'd0, ld_miss}, 32'd0);
        n = 0;
        while (!i_rdy && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        checkOutput("bypass_irdy_seen", {31'd0, i_rdy}, 32'd1);
        ir_ld = 1'b1;
        tick();
        ir_ld = 1'b0;
`ifdef FETCH_BYPASS_EN
        checkOutput("bypass_ir", {16'd0, ir}, 32'h2A95);
        checkOutput("bypass_miss", {31'd0, ld_miss}, 32'd0);
`else
        checkOutput("bypass_ir", {16'd0, ir}, 32'h50FF);
        checkOutput("bypass_miss", {31'd0, ld_miss}, 32'd1);
`endif
        checkOutput("bypass_rdy", {31'd0, fetch_rdy}, 32'd1);

        // Asynchronous reset in the middle of a fetch.
        latency = 10;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitRd();
        reset = 1'b1;
        #1;
        checkOutput("async_rd", {31'd0, i_rd}, 32'd0);
        checkOutput("async_pc", {24'd0, pc}, 32'd0);
        checkOutput("async_ir", {16'd0, ir}, 32'd0);
        checkOutput("async_rdy", {31'd0, fetch_rdy}, 32'd0);
        tick();
        reset   = 1'b0;
        exp_pc  = 8'h00;
        latency = 1;
        sbq.delete();
        waitReady();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("post_reset_ir", {16'd0, ir}, 32'h1A95);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-side responder to the Control_Unit: owns the program counter (PC) and instruction register (IR), and fetches 16-bit words from instruction memory over a request/ready handshake.
- Executes the PC_CLR, PC_IC and IR_LD commands issued by the control unit, and reports FETCH_RDY so the control FSM can stall until a word is buffered.
- Sits between Control_Unit (IR consumer) and the instruction ROM.

Parameters:
- ADDR_W, 8, PC / instruction address width; the PC wraps at 2^ADDR_W.
- DATA_W, 16, instruction word width.
- RESET_PC, 0, value loaded into PC on reset and on PC_CLR.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PC_CLR  in  1  from control unit: PC <= RESET_PC; discard any buffered or in-flight word.
- PC_IC  in  1  from control unit: PC <= PC+1; discard any buffered or in-flight word.
- IR_LD  in  1  from control unit: IR <= fetch buffer.
- IR  out  DATA_W  instruction register, to control unit.
- PC  out  ADDR_W  current program counter.
- FETCH_RDY  out  1  fetch buffer holds the valid word for the current PC.
- LD_MISS  out  1  one-cycle pulse: IR_LD arrived while the buffer was invalid.
- I_ADDR  out  ADDR_W  memory address, registered, stable while I_RD=1.
- I_RD  out  1  memory read request, held until I_RDY.
- I_DATA  in  DATA_W  memory read data, valid when I_RDY=1.
- I_RDY  in  1  memory data valid; one-cycle pulse per request.

Behaviour:
- Reset values: PC=RESET_PC, IR=0, FB=0, FETCH_RDY=0, LD_MISS=0, I_RD=0, I_ADDR=0, stale=0, state=LAUNCH.
- Reset mid-fetch: the request is abandoned; dropping I_RD cancels it under the memory contract.
- FSM states:
  - LAUNCH: I_RD=0. Next edge: I_ADDR <= PC, stale <= 0, go to FETCH.
  - FETCH: I_RD=1, I_ADDR held.
  - READY: FETCH_RDY=1, FB valid.
- FETCH transitions:
  - On I_RDY with stale=0 and no PC_CLR/PC_IC in the same cycle: FB <= I_DATA, go to READY.
  - On I_RDY otherwise: drop the word, go to LAUNCH.
  - PC_CLR or PC_IC without I_RDY: update PC, set stale=1, stay in FETCH with I_RD held until I_RDY. The request is never withdrawn early.
- READY transitions:
  - PC_CLR or PC_IC: update PC, go to LAUNCH, FETCH_RDY=0 next cycle.
  - Neither: stay in READY.
- PC_CLR has priority over PC_IC when both are asserted.
- PC arithmetic: PC+1 modulo 2^ADDR_W; (2^ADDR_W)-1 wraps to 0.
- IR_LD while FETCH_RDY=1: IR <= FB on that edge. Combined with PC_IC in the same cycle (normal step), IR takes the old PC's word and PC advances.
- IR_LD while FETCH_RDY=0: IR unchanged, LD_MISS=1 for the following cycle.
- Repeated IR_LD in READY reloads the same word.
- Minimum fetch latency: 3 cycles from a PC change to FETCH_RDY, with I_RDY returned in the cycle after I_RD rises.
- I_RD is low for at least one cycle between consecutive requests.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: in FETCH, when I_RDY=1, stale=0, no PC_CLR/PC_IC, and IR_LD=1 all coincide, IR <= I_DATA on that edge. No LD_MISS is raised; FB is also written and the FSM enters READY.
- Undefined: that case behaves as IR_LD with FETCH_RDY=0 (LD_MISS pulse, IR unchanged).

Test Plan:
- Reset, memory latency 1, mem[0]=16'h1A95 -> I_RD rises 1 cycle after Reset falls with I_ADDR=0; FETCH_RDY=1 after I_RDY; IR_LD gives IR=16'h1A95; PC=0.
- mem[1]=16'h2A95, latency 3; in READY pulse IR_LD+PC_IC -> IR=16'h1A95, PC=1, FETCH_RDY=0, then relaunch at I_ADDR=1; FETCH_RDY=1 with FB=16'h2A95.
- In FETCH at I_ADDR=5, latency 4, assert PC_CLR at cycle 2 -> I_RD held until I_RDY, word discarded, PC=0, new request at I_ADDR=0, FETCH_RDY only for mem[0].
- PC=8'hFF in READY, PC_IC -> PC=8'h00, fetch issued at I_ADDR=0; PC_CLR+PC_IC together -> PC=RESET_PC.
- IR_LD in FETCH with no I_RDY -> LD_MISS one-cycle pulse, IR unchanged; with FETCH_BYPASS_EN, IR_LD coinciding with I_RDY loads I_DATA and LD_MISS=0.
- Reset asserted mid-FETCH -> I_RD=0, PC=0, IR=0, FETCH_RDY=0 immediately (no clock edge needed).
